kmap_lut_pipe: RTL and testbench
================================

// Module: kmap_lut_pipe
// PURPOSE
//  Programmable multi-channel incompletely-specified Boolean function evaluator.
//  Each channel holds a 2^N_IN-entry K-map table whose entries are 0, 1 or don't-care.
//  Tables are written at run time; lookups stream through a valid/ready pipeline.
//  Don't-care hits are resolved to a fixed fill value, flagged, and counted.
//  Sits between the control-path config bus and any logic that consumes runtime-defined decode functions.
// PARAMETERS
//  N_IN     4   number of function inputs; table depth DEPTH = 2**N_IN
//  N_CH     2   number of independent function tables; CHW = max(1,$clog2(N_CH))
//  DC_FILL  0   value driven on out_f when the addressed entry is don't-care
//  CNT_W    16  width of the saturating don't-care hit counter
// PORTS
//  clk         in   1      clock, rising edge
//  areset      in   1      asynchronous reset, active-high
//  cfg_valid   in   1      table write request
//  cfg_ready   out  1      write accepted when cfg_valid & cfg_ready
//  cfg_ch      in   CHW    channel to write
//  cfg_addr    in   N_IN   minterm index to write
//  cfg_val     in   2      entry code: 2'b00=0, 2'b01=1, 2'b1x=don't-care
//  in_valid    in   1      lookup request
//  in_ready    out  1      lookup accepted when in_valid & in_ready
//  in_ch       in   CHW    channel to evaluate
//  in_x        in   N_IN   function inputs (minterm index)
//  out_valid   out  1      result available
//  out_ready   in   1      result consumed when out_valid & out_ready
//  out_f       out  1      function value (DC_FILL on don't-care)
//  out_dc      out  1      1 = addressed entry was don't-care
//  dc_clr      in   1      synchronous clear of dc_count
//  dc_count    out  CNT_W  saturating count of don't-care lookups accepted
//  busy        out  1      1 while table initialisation sweep runs
// BEHAVIOUR
//  - Reset values: cfg_ready=0, in_ready=0, out_valid=0, out_f=0, out_dc=0, dc_count=0, busy=1.
//  - FSM states INIT, RUN. areset -> INIT with sweep index 0.
//  - INIT: each cycle writes entry[index] := don't-care in all channels; index 0..DEPTH-1;
//    after index DEPTH-1 -> RUN (INIT lasts exactly DEPTH cycles). busy=1, cfg_ready=0, in_ready=0.
//  - RUN: busy=0, cfg_ready=1 always; in_ready = !out_valid | out_ready.
//  - Latency 1: lookup accepted on edge k -> out_valid=1 with out_f/out_dc after edge k.
//    out_valid held with stable out_f/out_dc until consumed; consume+accept same cycle = full throughput.
//  - Lookup and cfg write to same channel/address in same cycle: lookup returns the OLD entry;
//    write visible to lookups accepted on later cycles.
//  - cfg_ch >= N_CH or in_ch >= N_CH: write ignored (still acked); lookup returns out_dc=1, out_f=DC_FILL.
//  - dc_count increments on each accepted lookup whose result has out_dc=1; saturates at 2**CNT_W-1.
//    dc_clr and an increment in the same cycle -> dc_count=0 (clear wins).
//  - areset mid-operation: pending result dropped (out_valid=0), tables re-swept to don't-care.
// STRUCTURE
//  - Package kmap_pkg: typedef entry_t {logic care; logic val;}, constants ENT_ZERO, ENT_ONE, ENT_DC,
//    function decode_cfg(cfg_val) -> entry_t.
//  - Sub-module kmap_table: N_CH x DEPTH entry_t storage, one write port, one read port, INIT sweep
//    write path; top holds FSM, output register and counter.
//  - Table storage has no reset; only the sweep establishes contents.
// TESTING
//  1. Release areset; busy=1 for 16 cycles (N_IN=4) then cfg_ready=in_ready=1; lookup ch0 x=4'h5 ->
//     out_f=0, out_dc=1, dc_count=1.
//  2. Load ch0: 2,7,8,9->0; 4,6,B,C,E->1; rest DC. Lookup x=4'h2->0/0, 4'h4->1/0, 4'hB->1/0,
//     4'hA->DC_FILL/1; dc_count=1 after this step (cleared beforehand via dc_clr).
//  3. Same cycle: write ch1 addr 4'h3 := 1, lookup ch1 x=4'h3 -> out_dc=1; next lookup -> out_f=1, out_dc=0.
//  4. Hold out_ready=0 after one result: in_ready=0, out_f/out_dc stable 5 cycles; raise out_ready with
//     back-to-back lookups -> one result per cycle, no loss/duplication.
//  5. CNT_W=4: 20 don't-care lookups -> dc_count stops at 15; dc_clr with a DC lookup same cycle -> 0.
//  6. Assert areset while out_valid=1 -> out_valid=0 immediately; after sweep, previously loaded
//     entry 4'h4 reads out_dc=1.

Source files
------------

// File: rtl/kmap_pkg.sv
// Shared types for the runtime-programmable K-map evaluator: the entry encoding,
// the controller state type and the config-code decode helper.
package kmap_pkg;

    typedef struct packed {
        logic care;
        logic val;
    } entry_t;

    localparam entry_t ENT_ZERO = '{care: 1'b1, val: 1'b0};
    localparam entry_t ENT_ONE  = '{care: 1'b1, val: 1'b1};
    localparam entry_t ENT_DC   = '{care: 1'b0, val: 1'b0};

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    // Config code: 2'b00 -> 0, 2'b01 -> 1, 2'b1x -> don't-care.
    function automatic entry_t decode_cfg(input logic [1:0] cfg_val);
        if (cfg_val[1]) begin
            return ENT_DC;
        end
        return cfg_val[0] ? ENT_ONE : ENT_ZERO;
    endfunction

endpackage

// File: rtl/kmap_table.sv
// N_CH x 2**N_IN entry storage: one sweep/config write port and one
// combinational read port, so a same-cycle write is invisible to the read.
module kmap_table
    import kmap_pkg::*;
#(
    parameter int unsigned N_IN = 4,
    parameter int unsigned N_CH = 2,
    parameter int unsigned CHW  = 1
) (
    input  logic            clk,
    input  logic            sweep_en,
    input  logic [N_IN-1:0] sweep_addr,
    input  logic            wr_en,
    input  logic [CHW-1:0]  wr_ch,
    input  logic [N_IN-1:0] wr_addr,
    input  entry_t          wr_data,
    input  logic [CHW-1:0]  rd_ch,
    input  logic [N_IN-1:0] rd_addr,
    output entry_t          rd_data
);

    localparam int unsigned DEPTH = 2 ** N_IN;

    // No reset: contents are established only by the INIT sweep.
    entry_t mem_q [N_CH][DEPTH];

    always_ff @(posedge clk) begin
        if (sweep_en) begin
            for (int unsigned c = 0; c < N_CH; c++) begin
                mem_q[CHW'(c)][sweep_addr] <= ENT_DC;
            end
        end else if (wr_en && (32'(wr_ch) < N_CH)) begin
            mem_q[wr_ch][wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data = ENT_DC;
        if (32'(rd_ch) < N_CH) begin
            rd_data = mem_q[rd_ch][rd_addr];
        end
    end

endmodule

// File: rtl/kmap_lut_pipe.sv
// Multi-channel incompletely-specified Boolean function evaluator: INIT sweep
// controller, one-deep valid/ready result register and saturating DC counter.
module kmap_lut_pipe
    import kmap_pkg::*;
#(
    parameter int unsigned N_IN    = 4,
    parameter int unsigned N_CH    = 2,
    parameter bit          DC_FILL = 1'b0,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned CHW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CHW-1:0]   cfg_ch,
    input  logic [N_IN-1:0]  cfg_addr,
    input  logic [1:0]       cfg_val,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CHW-1:0]   in_ch,
    input  logic [N_IN-1:0]  in_x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_f,
    output logic             out_dc,
    input  logic             dc_clr,
    output logic [CNT_W-1:0] dc_count,
    output logic             busy
);

    state_t            state_q, state_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic              out_valid_q, out_valid_d;
    logic              out_f_q, out_f_d;
    logic              out_dc_q, out_dc_d;
    logic [CNT_W-1:0]  dc_count_q, dc_count_d;
    logic              sweep_en;
    logic              cfg_wr;
    logic              accept;
    entry_t            rd_entry;

    kmap_table #(
        .N_IN (N_IN),
        .N_CH (N_CH),
        .CHW  (CHW)
    ) u_table (
        .clk        (clk),
        .sweep_en   (sweep_en),
        .sweep_addr (idx_q),
        .wr_en      (cfg_wr),
        .wr_ch      (cfg_ch),
        .wr_addr    (cfg_addr),
        .wr_data    (decode_cfg(cfg_val)),
        .rd_ch      (in_ch),
        .rd_addr    (in_x),
        .rd_data    (rd_entry)
    );

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q     <= INIT;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_f_q     <= 1'b0;
            out_dc_q    <= 1'b0;
            dc_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_f_q     <= out_f_d;
            out_dc_q    <= out_dc_d;
            dc_count_q  <= dc_count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        busy      = 1'b0;
        cfg_ready = 1'b0;
        in_ready  = 1'b0;
        sweep_en  = 1'b0;
        case (state_q)
            INIT: begin
                busy     = 1'b1;
                sweep_en = 1'b1;
                idx_d    = idx_q + 1'b1;
                if (idx_q == '1) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                cfg_ready = 1'b1;
                in_ready  = !out_valid_q || out_ready;
            end
            default: state_d = INIT;
        endcase
    end

    assign cfg_wr = cfg_valid && cfg_ready;
    assign accept = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_f_d     = out_f_q;
        out_dc_d    = out_dc_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_f_d     = rd_entry.care ? rd_entry.val : DC_FILL;
            out_dc_d    = !rd_entry.care;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Clear has priority over a same-cycle increment.
    always_comb begin
        dc_count_d = dc_count_q;
        if (dc_clr) begin
            dc_count_d = '0;
        end else if (accept && !rd_entry.care && (dc_count_q != '1)) begin
            dc_count_d = dc_count_q + 1'b1;
        end
    end

    assign out_valid = out_valid_q;
    assign out_f     = out_f_q;
    assign out_dc    = out_dc_q;
    assign dc_count  = dc_count_q;

endmodule

// File: tb/tb_kmap_lut_pipe.sv
// Self-checking bench for kmap_lut_pipe: directed table vectors and corner
// sequences plus randomized traffic against an array-based reference model.
module tb_kmap_lut_pipe;

    localparam int unsigned N_IN    = 4;
    localparam int unsigned N_CH    = 3;
    localparam bit          DC_FILL = 1'b0;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CHW     = 2;
    localparam int unsigned DEPTH   = 2 ** N_IN;
    localparam int unsigned CNT_MAX = 2 ** CNT_W - 1;

    logic             clk;
    logic             areset;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CHW-1:0]   cfg_ch;
    logic [N_IN-1:0]  cfg_addr;
    logic [1:0]       cfg_val;
    logic             in_valid;
    logic             in_ready;
    logic [CHW-1:0]   in_ch;
    logic [N_IN-1:0]  in_x;
    logic             out_valid;
    logic             out_ready;
    logic             out_f;
    logic             out_dc;
    logic             dc_clr;
    logic [CNT_W-1:0] dc_count;
    logic             busy;

    kmap_lut_pipe #(
        .N_IN    (N_IN),
        .N_CH    (N_CH),
        .DC_FILL (DC_FILL),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .areset    (areset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_addr  (cfg_addr),
        .cfg_val   (cfg_val),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_f     (out_f),
        .out_dc    (out_dc),
        .dc_clr    (dc_clr),
        .dc_count  (dc_count),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: table values 0, 1, or 2 (= don't-care).
    int unsigned mtbl [N_CH][DEPTH];
    int unsigned since;
    bit          m_valid, m_f, m_dc;
    int unsigned m_cnt;
    int          checks;
    int          errors;

    typedef struct {
        int unsigned ch;
        int unsigned x;
        bit          f;
        bit          dc;
        string       name;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        since   = 0;
        m_valid = 0;
        m_f     = 0;
        m_dc    = 0;
        m_cnt   = 0;
    endtask

    task automatic model_edge();
        bit          acc;
        int unsigned e;
        acc = 0;
        e   = 2;
        if (areset) begin
            model_reset();
            return;
        end
        if (since < DEPTH) begin
            for (int unsigned c = 0; c < N_CH; c++) mtbl[c][since] = 2;
            since++;
        end else begin
            acc = in_valid && (!m_valid || out_ready);
            if (acc) e = (32'(in_ch) < N_CH) ? mtbl[in_ch][in_x] : 2;
            if (cfg_valid && (32'(cfg_ch) < N_CH))
                mtbl[cfg_ch][cfg_addr] = cfg_val[1] ? 2 : 32'(cfg_val[0]);
            if (acc) begin
                m_valid = 1;
                m_dc    = (e == 2);
                m_f     = (e == 2) ? DC_FILL : e[0];
            end else if (out_ready) begin
                m_valid = 0;
            end
        end
        if (dc_clr) m_cnt = 0;
        else if (acc && e == 2 && m_cnt < CNT_MAX) m_cnt++;
    endtask

    task automatic check_all();
        chk("busy",      32'(busy),      32'(since < DEPTH));
        chk("cfg_ready", 32'(cfg_ready), 32'(since >= DEPTH));
        chk("in_ready",  32'(in_ready),  32'((since >= DEPTH) && (!m_valid || out_ready)));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_f",     32'(out_f),     32'(m_f));
        chk("out_dc",    32'(out_dc),    32'(m_dc));
        chk("dc_count",  32'(dc_count),  m_cnt);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        cfg_valid = 0;
        in_valid  = 0;
        dc_clr    = 0;
        out_ready = 1;
    endtask

    task automatic write(input int unsigned ch, input int unsigned addr, input logic [1:0] val);
        cfg_valid = 1;
        cfg_ch    = CHW'(ch);
        cfg_addr  = N_IN'(addr);
        cfg_val   = val;
        tick();
        cfg_valid = 0;
    endtask

    task automatic lookup(input int unsigned ch, input int unsigned x, input bit ef, input bit edc,
                          input string nm);
        in_valid  = 1;
        in_ch     = CHW'(ch);
        in_x      = N_IN'(x);
        out_ready = 1;
        tick();
        in_valid = 0;
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_f"},     32'(out_f),     32'(ef));
        chk({nm, "_dc"},    32'(out_dc),    32'(edc));
    endtask

    int unsigned xs [6];
    bit          xf [6];
    bit          xd [6];

    initial begin
        checks = 0;
        errors = 0;
        for (int unsigned c = 0; c < N_CH; c++)
            for (int unsigned a = 0; a < DEPTH; a++) mtbl[c][a] = 2;
        model_reset();

        vecs[0] = '{ch: 0, x: 4'h2, f: 1'b0, dc: 1'b0, name: "ld_x2"};
        vecs[1] = '{ch: 0, x: 4'h4, f: 1'b1, dc: 1'b0, name: "ld_x4"};
        vecs[2] = '{ch: 0, x: 4'hB, f: 1'b1, dc: 1'b0, name: "ld_xB"};
        vecs[3] = '{ch: 0, x: 4'hA, f: DC_FILL, dc: 1'b1, name: "ld_xA"};

        xs = '{4'hA, 4'h2, 4'h4, 4'hB, 4'hC, 4'h9};
        xf = '{DC_FILL, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        xd = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // 1. reset, sweep length, first lookup hits a swept don't-care
        areset = 1;
        cfg_ch = '0; cfg_addr = '0; cfg_val = '0; in_ch = '0; in_x = '0;
        idle();
        @(negedge clk);
        check_all();
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        tick();
        tick();
        areset = 0;
        for (int unsigned i = 0; i < DEPTH - 1; i++) tick();
        chk("sweep_busy_last", 32'(busy), 32'd1);
        tick();
        chk("sweep_done_busy", 32'(busy), 32'd0);
        chk("sweep_done_in_ready", 32'(in_ready), 32'd1);
        lookup(0, 4'h5, DC_FILL, 1'b1, "first");
        chk("first_cnt", 32'(dc_count), 32'd1);

        // 2. load channel 0 and read back through the vector table
        dc_clr = 1;
        tick();
        dc_clr = 0;
        chk("clr_cnt", 32'(dc_count), 32'd0);
        for (int unsigned a = 0; a < DEPTH; a++) begin
            if (a == 2 || a == 7 || a == 8 || a == 9) write(0, a, 2'b00);
            else if (a == 4 || a == 6 || a == 11 || a == 12 || a == 14) write(0, a, 2'b01);
            else write(0, a, (a % 2 == 1) ? 2'b11 : 2'b10);
        end
        foreach (vecs[i]) lookup(vecs[i].ch, vecs[i].x, vecs[i].f, vecs[i].dc, vecs[i].name);
        chk("load_cnt", 32'(dc_count), 32'd1);

        // 3. same-cycle write and lookup returns the old entry
        cfg_valid = 1; cfg_ch = 2'd1; cfg_addr = 4'h3; cfg_val = 2'b01;
        lookup(1, 4'h3, DC_FILL, 1'b1, "rw_old");
        cfg_valid = 0;
        lookup(1, 4'h3, 1'b1, 1'b0, "rw_new");
        write(2, 4'h5, 2'b01);
        lookup(2, 4'h5, 1'b1, 1'b0, "ch2_wr");

        // 4. backpressure hold, then full-throughput streaming
        lookup(0, 4'h4, 1'b1, 1'b0, "hold_src");
        out_ready = 0;
        in_valid  = 1;
        in_ch     = 2'd0;
        in_x      = 4'hA;
        #1;
        chk("hold_in_ready0", 32'(in_ready), 32'd0);
        for (int unsigned i = 0; i < 5; i++) begin
            tick();
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_f", 32'(out_f), 32'd1);
            chk("hold_dc", 32'(out_dc), 32'd0);
        end
        out_ready = 1;
        for (int unsigned i = 0; i < 6; i++) begin
            in_x = N_IN'(xs[i]);
            tick();
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_f", 32'(out_f), 32'(xf[i]));
            chk("stream_dc", 32'(out_dc), 32'(xd[i]));
        end
        in_valid = 0;
        tick();
        chk("stream_drain", 32'(out_valid), 32'd0);

        // 5. saturation, ignored out-of-range channel, clear beats increment
        dc_clr = 1;
        tick();
        dc_clr = 0;
        write(3, 4'h5, 2'b01);
        in_valid = 1;
        for (int unsigned i = 0; i < 20; i++) begin
            in_ch = (i % 2 == 0) ? 2'd3 : 2'd0;
            in_x  = (i % 2 == 0) ? 4'h5 : 4'hA;
            tick();
            chk("sat_dc", 32'(out_dc), 32'd1);
        end
        in_valid = 0;
        chk("sat_cnt", 32'(dc_count), 32'(CNT_MAX));
        dc_clr = 1;
        lookup(0, 4'hA, DC_FILL, 1'b1, "clr_win");
        dc_clr = 0;
        chk("clr_win_cnt", 32'(dc_count), 32'd0);

        // 6. asynchronous reset drops a pending result and re-sweeps
        lookup(0, 4'h4, 1'b1, 1'b0, "pre_rst");
        out_ready = 0;
        tick();
        chk("pre_rst_held", 32'(out_valid), 32'd1);
        areset = 1;
        #1;
        model_reset();
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd1);
        tick();
        @(negedge clk);
        areset = 0;
        out_ready = 1;
        for (int unsigned i = 0; i < DEPTH; i++) tick();
        lookup(0, 4'h4, DC_FILL, 1'b1, "post_rst");

        // 7. randomized traffic against the model
        for (int unsigned i = 0; i < 800; i++) begin
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch    = CHW'($urandom_range(0, 3));
            cfg_addr  = N_IN'($urandom);
            cfg_val   = 2'($urandom);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_ch     = CHW'($urandom_range(0, 3));
            in_x      = N_IN'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            dc_clr    = ($urandom_range(0, 31) == 0);
            tick();
        end
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
